// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: word widths, reset
// vector default, and the fetch-queue entry layout.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // One buffered fetch: the instruction word and the address after it.
  typedef struct packed {
    instr_t instr;
    addr_t  pc4;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Fetch addresses are always word aligned; the low bits are dropped.
  function automatic addr_t word_align(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order buffer of fetched instructions. Single-cycle push and pop,
// flush empties it; a pop on an empty queue or a push on a full queue is
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head_data,
  output logic [CW-1:0]      count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign do_push   = push && (count_q != CW'(DEPTH)) && !flush;
  assign do_pop    = pop && (count_q != '0) && !flush;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to a
// variable-latency memory, queues returned words with PC+4, and flushes
// queued and in-flight fetches on a branch/jump redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  addr_t          fetch_pc_q, fetch_pc_d;
  addr_t          resp_pc_q, resp_pc_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  drop_q, drop_d;

  logic [CW-1:0]  q_count;
  logic [ENTRY_W-1:0] q_head;
  fetch_entry_t   push_entry, head_entry;
  logic           credit_ok, req_fire, resp_keep, q_pop;

  // Queue slots plus outstanding requests never exceed DEPTH, so every
  // response is guaranteed a slot without back-pressuring memory.
  assign credit_ok      = (SW'(q_count) + SW'(inflight_q)) < SW'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep        = imem_resp_valid && !redirect_valid && (drop_q == '0);
  assign push_entry.instr = imem_resp_data;
  assign push_entry.pc4   = resp_pc_q + 32'd4;

  assign head_entry = fetch_entry_t'(q_head);
  assign out_valid  = (q_count != '0);
  assign out_instr  = head_entry.instr;
  assign out_pc4    = head_entry.pc4;
  assign q_pop      = out_valid && out_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count)
  );

  // PC, outstanding-request and discard bookkeeping. A redirect takes
  // priority; responses already in flight at that point are discarded by
  // loading drop with the requests that are still to return.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_d     = inflight_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. The driver loads the expected
// instruction stream whenever it restarts fetch (reset/redirect); a
// negedge monitor models the instruction memory and pops/compares every
// instruction the datapath accepts.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_instr, out_pc4;
  logic        redirect_valid, out_valid, out_ready;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc4(out_pc4)
  );

  typedef struct { int due; logic [31:0] data; } pend_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int          vectors = 0, errors = 0, cyc = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, ready_toggle = 0;
  int          last_due = 0, fires = 0, accepts = 0;
  logic [31:0] key = 32'h0, exp_fetch = 32'h0, stall_addr = 32'h0;
  logic        stall_prev = 1'b0, rst_prev = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Expected stream after fetch restarts at address a: memory word for a,
  // a+4, ... each paired with its successor address.
  function automatic void restart(input logic [31:0] a);
    logic [31:0] p;
    p = a;
    exp_q.delete();
    exp_fetch = a;
    for (int i = 0; i < 600; i++) begin
      exp_q.push_back('{instr: p ^ key, pc4: p + 32'd4});
      p = p + 32'd4;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory response/ready driver, updated just after each rising edge.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (ready_toggle != 0) imem_req_ready = ~imem_req_ready;
      else imem_req_ready = ($urandom_range(99) < ready_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend[0].data;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // Monitor: memory bookkeeping plus every output comparison.
  always @(negedge clk) begin
    exp_t e;
    int   due;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      pend.delete();
      last_due   = 0;
      stall_prev = 1'b0;
      rst_prev   = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        if (!redirect_valid) chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      end
      rst_prev = 1'b0;
      chk("credit_inflight", 32'(pend.size() <= DEPTH), 32'd1);
      if (redirect_valid) chk("redirect_no_req", 32'(imem_req_valid), 32'd0);
      if (stall_prev && imem_req_valid) chk("addr_stable", imem_req_addr, stall_addr);
      if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{due: due, data: imem_req_addr ^ key});
        fires++;
      end
      stall_prev = imem_req_valid && !imem_req_ready;
      stall_addr = imem_req_addr;
      if (out_valid && out_ready && !redirect_valid) begin
        accepts++;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_pc4", out_pc4, e.pc4);
        end
      end
    end
  end

  task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic ordy);
    @(posedge clk); #1;
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = ordy;
    if (r) restart(RST_PC);
    else if (rv) restart({rpc[31:2], 2'b00});
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    int got;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    restart(RST_PC);

    // Streaming with 1-cycle memory: first instruction at cycle 2, then one per cycle.
    tick(1, 0, 0, 1); tick(1, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 0, 1); look();
      chk("stream_out_valid", 32'(out_valid), (k < 2) ? 32'd0 : 32'd1);
    end

    // Stalled consumer: exactly DEPTH requests accepted, then none.
    tick(1, 0, 0, 0);
    fires = 0;
    for (int k = 0; k < 10; k++) tick(0, 0, 0, 0);
    look();
    chk("stall_fires", 32'(fires), 32'(DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    accepts = 0;
    for (int k = 0; k < 20; k++) tick(0, 0, 0, 1);
    look();
    chk("release_accepts", 32'(accepts), 32'd20);

    // 3-cycle memory, redirect to 0x103 with three requests outstanding.
    lat_min = 3; lat_max = 3;
    tick(1, 0, 0, 1);
    got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      tick(0, 0, 0, 1); look();
      if (pend.size() == 3) got = 1;
    end
    chk("wait_three_inflight", 32'(got), 32'd1);
    tick(0, 1, 32'h0000_0103, 1);
    for (int k = 0; k < 15; k++) tick(0, 0, 0, 1);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    tick(1, 0, 0, 1);
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 1);
    tick(0, 1, 32'h0000_2000, 1); look();
    chk("coincide_resp_present", 32'(imem_resp_valid && out_valid), 32'd1);
    tick(0, 0, 0, 1); look();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("redirect_req_next", 32'(imem_req_valid), 32'd1);
    for (int k = 0; k < 10; k++) tick(0, 0, 0, 1);

    // Ready toggling across the address wrap.
    ready_toggle = 1;
    tick(0, 1, 32'hFFFF_FFF8, 1);
    fires = 0;
    for (int k = 0; k < 14; k++) tick(0, 0, 0, 1);
    look();
    chk("wrap_fires", 32'(fires >= 3), 32'd1);
    ready_toggle = 0;

    // Reset with a busy queue and requests outstanding.
    lat_min = 2; lat_max = 2;
    tick(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
    look();
    chk("busy_before_rst", 32'(out_valid && pend.size() > 0), 32'd1);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1); look();
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 10; k++) tick(0, 0, 0, 1);

    // Randomised traffic.
    lat_min = 1; lat_max = 3; ready_pct = 80;
    key = 32'h5A5A_0000;
    tick(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      tick($urandom_range(199) == 0, $urandom_range(19) == 0, tgt, $urandom_range(9) < 7);
    end
    tick(0, 0, 0, 0);
    look();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
